stopwatch_mmss: RTL and testbench

STOPWATCH_MMSS -- requirements
Module: stopwatch_mmss

---
 rtl/stopwatch_mmss.sv | 129 ++++++++++++
 tb/tb_stopwatch_mmss.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_mmss.sv
// MM:SS stopwatch: BCD seconds/minutes cascade advanced by a one-second tick,
// with an IDLE/RUN/PAUSE/DONE control FSM and a rollover-or-saturate policy at 59:59.
module stopwatch_mmss #(
  parameter int WRAP_EN = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_start_stop,
  input  logic       i_clear,
  output logic [3:0] o_sec_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_min_tens,
  output logic [1:0] o_state,
  output logic       o_running,
  output logic       o_wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic       running_q, running_d;
  logic       wrap_q, wrap_d;

  logic count_en;
  logic at_max;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      running_q  <= running_d;
      wrap_q     <= wrap_d;
    end
  end

  // Ticks are qualified by the registered state, so a tick coinciding with a
  // RUN->PAUSE press still counts while PAUSE->RUN / IDLE->RUN presses do not.
  assign count_en = (state_q == RUN) && i_tick;
  assign at_max   = (min_tens_q == 4'd5) && (min_ones_q == 4'd9) &&
                    (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);

  always_comb begin
    state_d    = state_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    wrap_d     = 1'b0;

    if (i_clear) begin
      state_d    = IDLE;
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else begin
      if (i_start_stop) begin
        case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = PAUSE;
          PAUSE:   state_d = RUN;
          default: state_d = DONE;
        endcase
      end

      if (count_en) begin
        if (at_max) begin
          if (WRAP_EN != 0) begin
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
            wrap_d     = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else if (sec_ones_q == 4'd9) begin
          sec_ones_d = 4'd0;
          if (sec_tens_q == 4'd5) begin
            sec_tens_d = 4'd0;
            if (min_ones_q == 4'd9) begin
              min_ones_d = 4'd0;
              min_tens_d = min_tens_q + 4'd1;
            end else begin
              min_ones_d = min_ones_q + 4'd1;
            end
          end else begin
            sec_tens_d = sec_tens_q + 4'd1;
          end
        end else begin
          sec_ones_d = sec_ones_q + 4'd1;
        end
      end
    end

    running_d = (state_d == RUN);
  end

  assign o_sec_ones = sec_ones_q;
  assign o_sec_tens = sec_tens_q;
  assign o_min_ones = min_ones_q;
  assign o_min_tens = min_tens_q;
  assign o_state    = state_q;
  assign o_running  = running_q;
  assign o_wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_mmss.sv
// Scoreboarded bench: a rollover and a saturating instance share stimulus and
// are checked every cycle against an elapsed-seconds reference model.
module tb_stopwatch_mmss;

  logic clk;
  logic i_reset, i_tick, i_start_stop, i_clear;

  logic [3:0] so1, st1, mo1, mt1, so0, st0, mo0, mt0;
  logic [1:0] state1, state0;
  logic       run1, run0, wrap1, wrap0;

  stopwatch_mmss #(.WRAP_EN(1)) dut_wrap (
    .i_clk(clk), .i_reset(i_reset), .i_tick(i_tick),
    .i_start_stop(i_start_stop), .i_clear(i_clear),
    .o_sec_ones(so1), .o_sec_tens(st1), .o_min_ones(mo1), .o_min_tens(mt1),
    .o_state(state1), .o_running(run1), .o_wrap(wrap1)
  );

  stopwatch_mmss #(.WRAP_EN(0)) dut_sat (
    .i_clk(clk), .i_reset(i_reset), .i_tick(i_tick),
    .i_start_stop(i_start_stop), .i_clear(i_clear),
    .o_sec_ones(so0), .o_sec_tens(st0), .o_min_ones(mo0), .o_min_tens(mt0),
    .o_state(state0), .o_running(run0), .o_wrap(wrap0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] e_wrap;
    logic [19:0] e_sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state: elapsed seconds plus state code, index 0 = wrap, 1 = saturate.
  int m_t[2];
  int m_st[2];
  bit m_w[2];

  function automatic logic [19:0] pack_exp(int t, int st, bit w);
    int sec, mn;
    sec = t % 60;
    mn  = t / 60;
    return {4'(mn / 10), 4'(mn % 10), 4'(sec / 10), 4'(sec % 10), 2'(st), (st == 1), w};
  endfunction

  task automatic step(input bit rst, input bit clr, input bit ss, input bit tk);
    int nst;
    @(negedge clk);
    i_reset = rst; i_clear = clr; i_start_stop = ss; i_tick = tk;
    for (int k = 0; k < 2; k++) begin
      if (rst || clr) begin
        m_t[k] = 0; m_st[k] = 0; m_w[k] = 0;
      end else begin
        nst    = m_st[k];
        m_w[k] = 0;
        if (ss) begin
          if (m_st[k] == 0)      nst = 1;
          else if (m_st[k] == 1) nst = 2;
          else if (m_st[k] == 2) nst = 1;
        end
        if (tk && m_st[k] == 1) begin
          if (m_t[k] == 3599) begin
            if (k == 0) begin m_t[k] = 0; m_w[k] = 1; end
            else nst = 3;
          end else begin
            m_t[k] = m_t[k] + 1;
          end
        end
        m_st[k] = nst;
      end
    end
    exp_q.push_back('{e_wrap: pack_exp(m_t[0], m_st[0], m_w[0]),
                      e_sat:  pack_exp(m_t[1], m_st[1], m_w[1])});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1);
  endtask

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got mm:ss=%h%h:%h%h st=%0d run=%b wrap=%b, expected mm:ss=%h%h:%h%h st=%0d run=%b wrap=%b",
               name, act[19:16], act[15:12], act[11:8], act[7:4], act[3:2], act[1], act[0],
               exp_v[19:16], exp_v[15:12], exp_v[11:8], exp_v[7:4], exp_v[3:2], exp_v[1], exp_v[0]);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wrap_dut", {mt1, mo1, st1, so1, state1, run1, wrap1}, e.e_wrap);
        check("sat_dut",  {mt0, mo0, st0, so0, state0, run0, wrap0}, e.e_sat);
      end
    end
  end

  initial begin
    int waited;
    i_reset = 1'b1; i_clear = 1'b0; i_start_stop = 1'b0; i_tick = 1'b0;
    for (int k = 0; k < 2; k++) begin m_t[k] = 0; m_st[k] = 0; m_w[k] = 0; end

    // Reset state, with every other input asserted alongside reset.
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    step(0, 0, 0, 0);

    // Start, then 61 ticks -> 01:01 RUN.
    step(0, 0, 1, 0);
    ticks(61);

    // 09:59 -> 10:00, then on to 59:59 and the rollover / saturation tick.
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    ticks(599);
    ticks(1);
    ticks(3599 - 600);
    ticks(1);
    step(0, 0, 1, 0);   // ignored in DONE; pauses the wrapping instance
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);

    // Pause/resume coincident with ticks at 00:05.
    step(0, 0, 1, 0);
    ticks(5);
    step(0, 0, 1, 1);
    ticks(3);
    step(0, 0, 1, 1);
    ticks(2);

    // 12:34 then clear with start_stop and tick on the same edge.
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    ticks(754);
    step(0, 1, 1, 1);
    step(0, 0, 1, 0);
    ticks(4);
    step(1, 1, 0, 1);

    // Reset applied while the rollover pulse is visible.
    step(0, 0, 1, 0);
    ticks(3600);
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(199, 0) == 0),
           ($urandom_range(99, 0) < 2),
           ($urandom_range(99, 0) < 6),
           ($urandom_range(99, 0) < 60));
    end
    step(0, 0, 0, 0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
